load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// Parametrised memory-access sequencer between the core's execute stage and the data bus.
// Accepts one load/store request at a time and drives valid/ready handshakes on both sides.
// Adds byte/half/word sizing, sign extension, byte enables and split misaligned accesses.
// Core-side results carry a register tag so the core can write back without stalling its decode.
// PARAMETERS
// DATA_WIDTH      16  bus/register width in bits; multiple of 8, power of 2; BYTES = DATA_WIDTH/8
// ADDR_WIDTH      16  byte-address width
// TAG_WIDTH       4   width of the register tag echoed with each response
// ALLOW_MISALIGNED 1  1: split misaligned accesses into two beats; 0: reject them with RespError
// PORTS
// MainClock     in   1           single clock; all state changes on its rising edge
// Reset         in   1           synchronous, active-low; sampled on MainClock
// ReqValid      in   1           request present
// ReqReady      out  1           unit can accept a request
// ReqWrite      in   1           1 = store, 0 = load
// ReqSize       in   2           log2(access bytes): 0 byte, 1 half, 2 word, 3 dword
// ReqSigned     in   1           sign-extend load result
// ReqAddress    in   ADDR_WIDTH  byte address, little-endian
// ReqData       in   DATA_WIDTH  store data, right-justified
// ReqTag        in   TAG_WIDTH   target register tag
// RespValid     out  1           response present
// RespReady     in   1           core takes response
// RespData      out  DATA_WIDTH  load result, right-justified, extended; 0 for stores
// RespTag       out  TAG_WIDTH   tag of the completed request
// RespError     out  1           request rejected; no bus activity was performed
// BusValid      out  1           bus transaction present
// BusWrite      out  1           1 = write beat
// BusAddress    out  ADDR_WIDTH  BYTES-aligned address (low log2(BYTES) bits 0)
// BusByteEnable out  BYTES       active byte lanes
// BusDataOut    out  DATA_WIDTH  lane-positioned write data; 0 for reads
// BusReady      in   1           beat completes in a cycle where BusValid & BusReady
// BusDataIn     in   DATA_WIDTH  read data, sampled in the completing cycle
// BEHAVIOUR
// - Reset low: state IDLE; every output 0 except ReqReady = 1 after release; in-flight access dropped.
// - States: IDLE, BEAT0, BEAT1, RESP. ReqReady = 1 only in IDLE. Accept = ReqValid & ReqReady.
// - Accept with n = 1<<ReqSize > BYTES, or misaligned with ALLOW_MISALIGNED=0 -> RESP, RespError = 1.
// - Otherwise latch request; off = ReqAddress mod BYTES; IDLE -> BEAT0. Split = off+n > BYTES.
// - BEAT0: BusAddress = aligned addr; BusByteEnable = lanes off..min(off+n,BYTES)-1;
//   BusDataOut = ReqData << 8*off (truncated). BusValid & BusReady: Split ? BEAT1 : RESP.
// - BEAT1: BusAddress = aligned addr + BYTES (wraps mod 2^ADDR_WIDTH); lanes 0..off+n-BYTES-1;
//   BusDataOut = ReqData >> 8*(BYTES-off). BusValid & BusReady -> RESP.
// - Bus outputs are registered and held stable while BusValid & !BusReady; no timeout.
// - Load merge: beat0 lanes -> result bytes 0.., beat1 lanes -> following bytes; bytes >= n are
//   zero, or copies of bit 8n-1 when ReqSigned.
// - RESP: RespValid = 1, outputs held until RespReady; then IDLE, with a new request accepted
//   no earlier than the following cycle.
// - Latency (aligned, BusReady already high): accept T, BusValid T+1, RespValid T+2.
//   Split: RespValid T+3. Each BusReady-low cycle adds one.
// TESTING (DATA_WIDTH=16, BYTES=2)
// 1. Aligned half load 0x0010, tag 5, BusDataIn 0xBEEF -> BusByteEnable 2'b11, RespData 0xBEEF, RespTag 5 at T+2.
// 2. Byte load 0x0011, BusDataIn 0x80AA -> BE 2'b10; ReqSigned=1 RespData 0xFF80; ReqSigned=0 0x0080.
// 3. Half load 0x0011: beat0 addr 0x0010 BE 2'b10 data 0x3400; beat1 addr 0x0012 BE 2'b01 data 0x0012 -> 0x1234 at T+3.
// 4. Half store 0x0011 data 0xABCD -> beat0 0x0010 BE 2'b10 BusDataOut 0xCD00; beat1 0x0012 BE 2'b01 0x00AB; RespData 0.
// 5. ReqSize=2, or ALLOW_MISALIGNED=0 with half at 0x0011 -> RespError=1 at T+1; BusValid never 1.
// 6. BusReady low 5 cycles (BusAddress stable), then Reset low -> all outputs 0; RespReady low holds RespValid.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, response and data-bus signals of the load/store unit.
// The unit itself uses the slave view; the core/bus environment uses the master view.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWrite;
    logic [1:0]            ReqSize;
    logic                  ReqSigned;
    logic [ADDR_WIDTH-1:0] ReqAddress;
    logic [DATA_WIDTH-1:0] ReqData;
    logic [TAG_WIDTH-1:0]  ReqTag;

    logic                  RespValid;
    logic                  RespReady;
    logic [DATA_WIDTH-1:0] RespData;
    logic [TAG_WIDTH-1:0]  RespTag;
    logic                  RespError;

    logic                  BusValid;
    logic                  BusWrite;
    logic [ADDR_WIDTH-1:0] BusAddress;
    logic [BYTES-1:0]      BusByteEnable;
    logic [DATA_WIDTH-1:0] BusDataOut;
    logic                  BusReady;
    logic [DATA_WIDTH-1:0] BusDataIn;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqData, ReqTag,
        output ReqReady,
        output RespValid, RespData, RespTag, RespError,
        input  RespReady,
        output BusValid, BusWrite, BusAddress, BusByteEnable, BusDataOut,
        input  BusReady, BusDataIn
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddress, ReqData, ReqTag,
        input  ReqReady,
        input  RespValid, RespData, RespTag, RespError,
        output RespReady,
        input  BusValid, BusWrite, BusAddress, BusByteEnable, BusDataOut,
        output BusReady, BusDataIn
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: sizes, aligns and (optionally) splits one core memory request
// into one or two data-bus beats, then returns a tagged, extended result.
module load_store_unit #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 16,
    parameter int TAG_WIDTH        = 4,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic              MainClock,
    input logic              Reset,
    load_store_unit_if.slave lsu
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state;

    logic                  req_ready;
    logic                  bus_valid;
    logic                  bus_write;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [BYTES-1:0]      bus_byte_enable;
    logic [DATA_WIDTH-1:0] bus_data_out;
    logic                  resp_valid;
    logic                  resp_error;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;

    logic                  r_write;
    logic                  r_signed;
    logic [1:0]            r_size;
    logic [7:0]            r_off;
    logic                  r_split;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_merge;

    int unsigned           req_n;
    int unsigned           req_off;
    logic                  req_reject;
    logic                  req_split;
    logic [BYTES-1:0]      req_be;
    int                    sh_lo;
    int                    sh_hi;
    int                    beat1_end;
    logic [BYTES-1:0]      beat1_be;
    logic [DATA_WIDTH-1:0] merge0;
    logic [DATA_WIDTH-1:0] merge1;

    // Bytes at and above n are zero, or copies of bit 8n-1 for signed loads.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                     input int n, input logic sext);
        logic [DATA_WIDTH-1:0] res;
        logic fill;
        res  = '0;
        fill = sext & raw[8*n-1];
        for (int i = 0; i < DATA_WIDTH; i++) res[i] = (i < 8*n) ? raw[i] : fill;
        return res;
    endfunction

    // NOTE: every variable written here gets a value before any conditional use, so no latch is inferred.
    always_comb begin
        req_n      = 32'd1 << lsu.ReqSize;
        req_off    = 32'(lsu.ReqAddress & LANE_MASK);
        req_split  = (req_off + req_n) > BYTES;
        req_reject = (req_n > BYTES) ||
                     (!ALLOW_MISALIGNED && ((32'(lsu.ReqAddress) & (req_n - 1)) != 0));
        req_be = '0;
        for (int unsigned i = 0; i < BYTES; i++)
            req_be[i] = (i >= req_off) && (i < req_off + req_n);

        sh_lo     = 8 * int'(r_off);
        sh_hi     = 8 * (BYTES - int'(r_off));
        beat1_end = int'(r_off) + (1 << r_size) - BYTES;
        beat1_be  = '0;
        for (int i = 0; i < BYTES; i++) beat1_be[i] = i < beat1_end;
        merge0 = lsu.BusDataIn >> sh_lo;
        merge1 = r_merge | (lsu.BusDataIn << sh_hi);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MainClock) begin
        if (!Reset) begin
            state           <= IDLE;
            req_ready       <= 1'b0;
            bus_valid       <= 1'b0;
            bus_write       <= 1'b0;
            bus_address     <= '0;
            bus_byte_enable <= '0;
            bus_data_out    <= '0;
            resp_valid      <= 1'b0;
            resp_error      <= 1'b0;
            resp_data       <= '0;
            resp_tag        <= '0;
            // NOTE: request latches are left unreset; they are only read after an accept has loaded them.
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (lsu.ReqValid && req_ready) begin
                        req_ready <= 1'b0;
                        r_write   <= lsu.ReqWrite;
                        r_signed  <= lsu.ReqSigned;
                        r_size    <= lsu.ReqSize;
                        r_off     <= 8'(req_off);
                        r_split   <= req_split;
                        r_data    <= lsu.ReqData;
                        resp_tag  <= lsu.ReqTag;
                        if (req_reject) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state           <= BEAT0;
                            bus_valid       <= 1'b1;
                            bus_write       <= lsu.ReqWrite;
                            bus_address     <= lsu.ReqAddress & ~LANE_MASK;
                            bus_byte_enable <= req_be;
                            bus_data_out    <= lsu.ReqWrite ? (lsu.ReqData << (8 * req_off)) : '0;
                        end
                    end
                end
                BEAT0: begin
                    if (lsu.BusReady) begin
                        r_merge <= merge0;
                        if (r_split) begin
                            state           <= BEAT1;
                            bus_address     <= bus_address + ADDR_WIDTH'(BYTES);
                            bus_byte_enable <= beat1_be;
                            bus_data_out    <= r_write ? (r_data >> sh_hi) : '0;
                        end else begin
                            state           <= RESP;
                            bus_valid       <= 1'b0;
                            bus_write       <= 1'b0;
                            bus_address     <= '0;
                            bus_byte_enable <= '0;
                            bus_data_out    <= '0;
                            resp_valid      <= 1'b1;
                            resp_error      <= 1'b0;
                            resp_data       <= r_write ? '0 : extend(merge0, 1 << r_size, r_signed);
                        end
                    end
                end
                BEAT1: begin
                    if (lsu.BusReady) begin
                        state           <= RESP;
                        bus_valid       <= 1'b0;
                        bus_write       <= 1'b0;
                        bus_address     <= '0;
                        bus_byte_enable <= '0;
                        bus_data_out    <= '0;
                        resp_valid      <= 1'b1;
                        resp_error      <= 1'b0;
                        resp_data       <= r_write ? '0 : extend(merge1, 1 << r_size, r_signed);
                    end
                end
                RESP: begin
                    if (lsu.RespReady) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        resp_data  <= '0;
                        resp_tag   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lsu.ReqReady      = req_ready;
    assign lsu.BusValid      = bus_valid;
    assign lsu.BusWrite      = bus_write;
    assign lsu.BusAddress    = bus_address;
    assign lsu.BusByteEnable = bus_byte_enable;
    assign lsu.BusDataOut    = bus_data_out;
    assign lsu.RespValid     = resp_valid;
    assign lsu.RespError     = resp_error;
    assign lsu.RespData      = resp_data;
    assign lsu.RespTag       = resp_tag;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory model serving the bus, directed
// cases for sizing/splitting/errors/reset, then randomized requests.
module tb_load_store_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TAG_WIDTH(4)) a ();
    load_store_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TAG_WIDTH(4)) s ();

    load_store_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TAG_WIDTH(4), .ALLOW_MISALIGNED(1'b1)) dut (
        .MainClock(clk), .Reset(rst_n), .lsu(a)
    );
    load_store_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TAG_WIDTH(4), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .MainClock(clk), .Reset(rst_n), .lsu(s)
    );

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] dout;
        logic        wr;
    } beat_t;

    beat_t       beats[$];
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] last_data;
    logic [3:0]  last_tag;
    logic        last_err;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {5'b0, a.ReqReady, a.RespValid, a.RespData, a.RespTag, a.RespError,
                a.BusValid, a.BusWrite, a.BusAddress, a.BusByteEnable, a.BusDataOut};
    endfunction

    function automatic beat_t beat_at(input int i);
        beat_t b;
        b = '{default: '0};
        if (i < beats.size()) b = beats[i];
        return b;
    endfunction

    // Reference load: little-endian bytes from the model memory, zero or sign filled.
    function automatic logic [15:0] model_load(input logic [15:0] addr, input int n, input logic sg);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[addr + 16'(k)];
        if (sg && v[8*n-1]) for (int k = 8*n; k < 16; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic poke(input logic [15:0] addr, input logic [7:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    // One complete request on the main unit; checks response, latency, beat count and memory effect.
    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [15:0] addr,
                       input logic [15:0] data, input logic [3:0] tag, input int stall, input int hold);
        int n, lat, st, exp_lat, exp_beats;
        logic err, split;
        logic [15:0] held, exp_data, base;
        n         = 1 << sz;
        err       = n > 2;
        split     = !err && (int'(addr[0]) + n > 2);
        exp_beats = err ? 0 : (split ? 2 : 1);
        exp_lat   = err ? 1 : exp_beats + 1 + stall;
        if (!err && wr) for (int k = 0; k < n; k++) ref_mem[addr + 16'(k)] = data[8*k +: 8];
        exp_data  = (err || wr) ? 16'h0 : model_load(addr, n, sg);
        beats.delete();
        st   = stall;
        held = '0;

        check("req_ready", a.ReqReady, 1);
        a.ReqValid = 1'b1; a.ReqWrite = wr; a.ReqSize = sz; a.ReqSigned = sg;
        a.ReqAddress = addr; a.ReqData = data; a.ReqTag = tag;
        @(posedge clk); @(negedge clk);
        a.ReqValid = 1'b0;
        lat = 1;
        while (lat < 60) begin
            a.BusReady = 1'b0;
            if (a.RespValid === 1'b1) break;
            if (a.BusValid === 1'b1) begin
                if (st > 0) begin
                    if (st == stall) held = a.BusAddress;
                    else check("bus_hold", a.BusAddress, held);
                    st--;
                end else begin
                    a.BusReady  = 1'b1;
                    a.BusDataIn = {mem[a.BusAddress + 16'd1], mem[a.BusAddress]};
                    if (a.BusWrite === 1'b1) begin
                        for (int i = 0; i < 2; i++)
                            if (a.BusByteEnable[i]) mem[a.BusAddress + 16'(i)] = a.BusDataOut[8*i +: 8];
                    end else begin
                        check("rd_dout_zero", a.BusDataOut, 0);
                    end
                    beats.push_back('{addr: a.BusAddress, be: a.BusByteEnable, dout: a.BusDataOut, wr: a.BusWrite});
                end
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        a.BusReady = 1'b0;
        last_data  = a.RespData;
        last_tag   = a.RespTag;
        last_err   = a.RespError;

        check("resp_seen", a.RespValid, 1);
        check("latency", lat, exp_lat);
        check("beats", beats.size(), exp_beats);
        check("resp_data", a.RespData, exp_data);
        check("resp_tag", a.RespTag, tag);
        check("resp_err", a.RespError, err);
        base = addr & 16'hFFFE;
        check("mem_span",
              {mem[base + 16'd3], mem[base + 16'd2], mem[base + 16'd1], mem[base]},
              {ref_mem[base + 16'd3], ref_mem[base + 16'd2], ref_mem[base + 16'd1], ref_mem[base]});

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("resp_hold", {a.RespValid, a.RespData, a.RespTag}, {1'b1, last_data, last_tag});
        end
        a.RespReady = 1'b1;
        @(posedge clk); @(negedge clk);
        a.RespReady = 1'b0;
        check("resp_drop", {a.RespValid, a.BusValid, a.ReqReady}, 3'b001);
    endtask

    initial begin
        a.ReqValid = 0; a.ReqWrite = 0; a.ReqSize = 0; a.ReqSigned = 0;
        a.ReqAddress = 0; a.ReqData = 0; a.ReqTag = 0;
        a.RespReady = 0; a.BusReady = 0; a.BusDataIn = 0;
        s.ReqValid = 0; s.ReqWrite = 0; s.ReqSize = 0; s.ReqSigned = 0;
        s.ReqAddress = 0; s.ReqData = 0; s.ReqTag = 0;
        s.RespReady = 0; s.BusReady = 0; s.BusDataIn = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", a.ReqReady, 1);

        // Aligned half load
        poke(16'h0010, 8'hEF); poke(16'h0011, 8'hBE);
        txn(1'b0, 2'd1, 1'b0, 16'h0010, 16'h0, 4'd5, 0, 0);
        check("t1_data", last_data, 16'hBEEF);
        check("t1_tag", last_tag, 4'd5);
        check("t1_beat", {beat_at(0).addr, beat_at(0).be}, {16'h0010, 2'b11});

        // Byte load, signed and unsigned
        poke(16'h0010, 8'hAA); poke(16'h0011, 8'h80);
        txn(1'b0, 2'd0, 1'b1, 16'h0011, 16'h0, 4'd2, 0, 0);
        check("t2_signed", last_data, 16'hFF80);
        check("t2_be", beat_at(0).be, 2'b10);
        txn(1'b0, 2'd0, 1'b0, 16'h0011, 16'h0, 4'd3, 1, 0);
        check("t2_unsigned", last_data, 16'h0080);

        // Split half load
        poke(16'h0010, 8'h00); poke(16'h0011, 8'h34); poke(16'h0012, 8'h12); poke(16'h0013, 8'h00);
        txn(1'b0, 2'd1, 1'b0, 16'h0011, 16'h0, 4'd7, 0, 0);
        check("t3_data", last_data, 16'h1234);
        check("t3_beat0", {beat_at(0).addr, beat_at(0).be}, {16'h0010, 2'b10});
        check("t3_beat1", {beat_at(1).addr, beat_at(1).be}, {16'h0012, 2'b01});

        // Split half store
        txn(1'b1, 2'd1, 1'b0, 16'h0011, 16'hABCD, 4'd8, 0, 0);
        check("t4_beat0", {beat_at(0).wr, beat_at(0).addr, beat_at(0).be, beat_at(0).dout},
                          {1'b1, 16'h0010, 2'b10, 16'hCD00});
        check("t4_beat1", {beat_at(1).wr, beat_at(1).addr, beat_at(1).be, beat_at(1).dout},
                          {1'b1, 16'h0012, 2'b01, 16'h00AB});
        check("t4_resp", last_data, 16'h0);

        // Oversize request rejected on the permissive unit
        txn(1'b0, 2'd2, 1'b0, 16'h0010, 16'h0, 4'd4, 0, 0);
        check("t5_err", last_err, 1);

        // Misaligned half rejected on the strict unit, without bus activity
        s.ReqValid = 1'b1; s.ReqSize = 2'd1; s.ReqAddress = 16'h0011; s.ReqTag = 4'h9;
        @(posedge clk); @(negedge clk);
        s.ReqValid = 1'b0;
        check("t5_strict", {s.RespValid, s.RespError, s.BusValid, s.RespTag}, {3'b110, 4'h9});
        s.RespReady = 1'b1;
        @(posedge clk); @(negedge clk);
        s.RespReady = 1'b0;
        check("t5_strict_idle", {s.RespValid, s.BusValid, s.ReqReady}, 3'b001);

        // Bus stall plus held response, and a split wrapping past the top of memory
        txn(1'b0, 2'd1, 1'b1, 16'h0031, 16'h0, 4'd11, 2, 3);
        txn(1'b0, 2'd1, 1'b0, 16'hFFFF, 16'h0, 4'd12, 0, 0);
        check("wrap_beat1", beat_at(1).addr, 16'h0000);

        // Stall for five cycles, then reset mid-access
        a.ReqValid = 1'b1; a.ReqWrite = 1'b0; a.ReqSize = 2'd1; a.ReqAddress = 16'h0020; a.ReqTag = 4'd6;
        @(posedge clk); @(negedge clk);
        a.ReqValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t6_stall", {a.BusValid, a.BusAddress, a.RespValid}, {1'b1, 16'h0020, 1'b0});
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("t6_ready", {a.ReqReady, a.BusValid, a.RespValid}, 3'b100);

        // Randomized traffic against the byte-memory model
        for (int it = 0; it < 60; it++) begin
            logic [1:0]  sz;
            logic [15:0] addr;
            sz   = ($urandom % 8 == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom % 2);
            addr = ($urandom % 4 == 0) ? (16'hFFF0 | 16'($urandom % 16)) : 16'($urandom);
            txn(1'($urandom), sz, 1'($urandom), addr, 16'($urandom), 4'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
